// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed display fetch slots every DATA_W pixels, CPU writes
// fill the remaining port cycles; fetched words are serialised into a 1bpp pixel stream.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LINE_WORDS = 100,
  parameter int unsigned PIPE_LAT   = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              dis_en,
  input  logic [9:0]        pixh,
  input  logic [9:0]        pixv,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              pix_out,
  output logic              pix_valid
);

  // dis_en stages ahead of pix_valid, and owner stages ahead of the shift-register load
  localparam int unsigned VD_W = PIPE_LAT - 1;
  localparam int unsigned SD_W = PIPE_LAT - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } owner_t;

  owner_t            owner;
  logic [ADDR_W-1:0] line_base_c;
  logic [ADDR_W-1:0] disp_addr_c;
  logic              slot_c;
  logic              grant_c;
  logic              next_bit_c;
  logic [VD_W-1:0]   valid_sr;
  logic [SD_W-1:0]   load_sr;
  logic [DATA_W-1:0] shreg;

  // Row base address; the 100-word line uses a shift-add instead of a multiplier
  if (LINE_WORDS == 100) begin : g_line_shift
    assign line_base_c = (ADDR_W'(pixv) << 6) + (ADDR_W'(pixv) << 5) + (ADDR_W'(pixv) << 2);
  end else begin : g_line_mul
    assign line_base_c = ADDR_W'(pixv) * ADDR_W'(LINE_WORDS);
  end

  assign disp_addr_c = line_base_c + ADDR_W'(pixh[9:3]);
  assign slot_c      = dis_en && (pixh[2:0] == 3'd0);
  // Blocking the grant while cpu_ack is high keeps a held request from writing twice
  assign grant_c     = cpu_req && !cpu_ack;
  assign next_bit_c  = load_sr[SD_W-1] ? vram_rdata[DATA_W-1] : shreg[DATA_W-1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      owner      <= IDLE;
      cpu_ack    <= 1'b0;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= '0;
      valid_sr   <= '0;
      load_sr    <= '0;
      shreg      <= '0;
      pix_out    <= 1'b0;
      pix_valid  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      vram_we <= 1'b0;
      if (slot_c) begin
        owner     <= DISP;
        vram_addr <= disp_addr_c;
      end else if (grant_c) begin
        owner      <= CPU;
        vram_addr  <= cpu_addr;
        vram_wdata <= cpu_wdata;
        vram_we    <= 1'b1;
        cpu_ack    <= 1'b1;
      end else begin
        owner <= IDLE;
      end

      // Read data arrives one cycle after the DISP cycle; load it then shift MSB-first
      load_sr  <= SD_W'({load_sr, owner == DISP});
      valid_sr <= VD_W'({valid_sr, dis_en});
      if (load_sr[SD_W-1]) begin
        shreg <= DATA_W'({vram_rdata, 1'b0});
      end else begin
        shreg <= DATA_W'({shreg, 1'b0});
      end
      pix_out   <= next_bit_c && valid_sr[VD_W-1];
      pix_valid <= valid_sr[VD_W-1];
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: RAM model, pixel/write expectation queues and a
// negedge monitor that pops and compares whenever the DUT presents a pixel or a write.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_WORDS = 65536;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              clr;
  logic              dis_en;
  logic [9:0]        pixh;
  logic [9:0]        pixv;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;
  logic              pix_out;
  logic              pix_valid;

  logic [DATA_W-1:0] ram     [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  bit                pix_q[$];
  wr_t               wr_q[$];
  int                checks    = 0;
  int                errors    = 0;
  int                valid_cnt = 0;
  bit                prev_ack  = 1'b0;
  bit                disp_done = 1'b0;

  vram_arbiter dut (
    .clk       (clk),
    .clr       (clr),
    .dis_en    (dis_en),
    .pixh      (pixh),
    .pixv      (pixv),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .vram_addr (vram_addr),
    .vram_we   (vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .pix_out   (pix_out),
    .pix_valid (pix_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel: word at row*100 + col/8, MSB is the leftmost pixel
  function automatic bit ref_pixel(input int v, input int h);
    logic [DATA_W-1:0] w;
    w = ref_mem[v * 100 + h / 8];
    return w[7 - (h % 8)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dis_en = 1'b0;
      pixh   = 10'($urandom);
      pixv   = 10'($urandom);
      step();
    end
  endtask

  task automatic drive_line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      dis_en = 1'b1;
      pixv   = 10'(v);
      pixh   = 10'(h);
      pix_q.push_back(ref_pixel(v, h));
      step();
    end
    dis_en = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int lat;
    wr_q.push_back('{addr: a, data: d});
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    lat = 0;
    while (lat < 8) begin
      step();
      lat++;
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
    chk("cpu_ack_seen", 32'(cpu_ack), 32'd1);
    chk("cpu_wait_le2", 32'(lat <= 2), 32'd1);
  endtask

  // RAM model: synchronous read-first single port
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0] = 8'hA5; ref_mem[0] = 8'hA5;
    ram[1] = 8'hFF; ref_mem[1] = 8'hFF;
    forever begin
      @(posedge clk);
      vram_rdata <= ram[vram_addr];
      if (vram_we) ram[vram_addr] = vram_wdata;
    end
  end

  // Monitor: pops expected pixels/writes when the DUT presents them
  initial begin
    bit  e;
    wr_t w;
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_ack = 1'b0;
      end else begin
        if (pix_valid) begin
          valid_cnt++;
          if (pix_q.size() == 0) chk("pix_unexpected", 32'(pix_valid), 32'd0);
          else begin
            e = pix_q.pop_front();
            chk("pix_out", 32'(pix_out), 32'(e));
          end
        end else begin
          chk("pix_blank_zero", 32'(pix_out), 32'd0);
        end
        if (cpu_ack) begin
          chk("ack_not_adjacent", 32'(prev_ack), 32'd0);
          chk("ack_with_we", 32'(vram_we), 32'd1);
          if (wr_q.size() == 0) chk("ack_unexpected", 32'(cpu_ack), 32'd0);
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(vram_addr), 32'(w.addr));
            chk("wr_data", 32'(vram_wdata), 32'(w.data));
            ref_mem[w.addr] = w.data;
          end
        end else begin
          chk("we_without_ack", 32'(vram_we), 32'd0);
        end
        prev_ack = cpu_ack;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    int t, t_first, t_second, lat;
    logic [ADDR_W-1:0] a0, a1, a2;
    logic [DATA_W-1:0] d0, d1, d2;

    clr = 1'b1; dis_en = 1'b0; pixh = '0; pixv = '0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      dis_en    = 1'($urandom);
      pixh      = 10'($urandom);
      pixv      = 10'($urandom);
      cpu_req   = 1'($urandom);
      cpu_addr  = 16'($urandom);
      cpu_wdata = 8'($urandom);
      step();
      chk("rst_outputs", 32'({vram_addr, vram_wdata, cpu_ack, vram_we, pix_out, pix_valid}), 32'd0);
    end
    dis_en = 1'b0; cpu_req = 1'b0; clr = 1'b0;
    step();
    chk("post_rst_we", 32'(vram_we), 32'd0);
    chk("post_rst_valid", 32'(pix_valid), 32'd0);
    idle(3);

    // Two preloaded words on row 0
    vc0 = valid_cnt;
    drive_line(0, 0, 15);
    idle(6);
    chk("t2_valid_cycles", 32'(valid_cnt - vc0), 32'd16);

    // Last word of the last row
    dis_en = 1'b1; pixv = 10'd599; pixh = 10'd792;
    pix_q.push_back(ref_pixel(599, 792));
    step();
    dis_en = 1'b0;
    chk("t3_addr", 32'(vram_addr), 32'd59999);
    chk("t3_we", 32'(vram_we), 32'd0);
    idle(5);

    // CPU write in blanking
    wr_q.push_back('{addr: 16'h0123, data: 8'h3C});
    cpu_addr = 16'h0123; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    step();
    chk("t4_we", 32'(vram_we), 32'd1);
    chk("t4_addr", 32'(vram_addr), 32'h0123);
    chk("t4_wdata", 32'(vram_wdata), 32'h3C);
    chk("t4_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    step();
    chk("t4_ack_pulse", 32'(cpu_ack), 32'd0);
    chk("t4_we_pulse", 32'(vram_we), 32'd0);
    idle(2);

    // CPU request collides with the pixh=8 display slot
    d0 = 8'($urandom);
    for (int h = 0; h <= 15; h++) begin
      dis_en = 1'b1; pixv = 10'd0; pixh = 10'(h);
      pix_q.push_back(ref_pixel(0, h));
      if (h == 8) begin
        wr_q.push_back('{addr: 16'd60001, data: d0});
        cpu_addr = 16'd60001; cpu_wdata = d0; cpu_req = 1'b1;
      end
      step();
      if (h == 8) begin
        chk("t5_disp_first_we", 32'(vram_we), 32'd0);
        chk("t5_disp_first_addr", 32'(vram_addr), 32'd1);
        chk("t5_no_ack_yet", 32'(cpu_ack), 32'd0);
      end
      if (h == 9) begin
        chk("t5_ack_next", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
      end
    end
    dis_en = 1'b0;
    idle(6);

    // Held request, two back-to-back writes
    a0 = 16'd60010; d0 = 8'($urandom);
    a1 = 16'd60011; d1 = 8'($urandom);
    wr_q.push_back('{addr: a0, data: d0});
    wr_q.push_back('{addr: a1, data: d1});
    cpu_addr = a0; cpu_wdata = d0; cpu_req = 1'b1;
    t = 0; t_first = -1; t_second = -1;
    while (t < 12 && t_second < 0) begin
      step();
      t++;
      if (cpu_ack) begin
        if (t_first < 0) begin
          t_first = t;
          cpu_addr = a1; cpu_wdata = d1;
        end else begin
          t_second = t;
        end
      end
    end
    cpu_req = 1'b0;
    chk("t6_first_lat", 32'(t_first), 32'd1);
    chk("t6_spacing", 32'(t_second - t_first), 32'd2);
    idle(2);

    // Reset pulse while a write is on the port
    a2 = 16'd60020; d2 = 8'($urandom);
    cpu_addr = a2; cpu_wdata = d2; cpu_req = 1'b1;
    step();
    #1 clr = 1'b1;
    #1;
    chk("t6_clr_we_drop", 32'(vram_we), 32'd0);
    chk("t6_clr_ack_drop", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    #1 clr = 1'b0;
    wr_q.push_back('{addr: a2, data: d2});
    lat = 0;
    while (lat < 8) begin
      step();
      lat++;
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
    chk("t6_resume_lat", 32'(lat), 32'd1);
    idle(3);

    // CPU writes into row 7 during blanking, then display row 7
    for (int k = 0; k < 4; k++) begin
      cpu_write(16'(700 + k), 8'($urandom));
      idle(1);
    end
    idle(2);
    drive_line(7, 0, 31);
    idle(6);

    // Random display lines with concurrent CPU traffic above the frame buffer
    fork
      begin
        for (int l = 0; l < 3; l++) begin
          drive_line(int'($urandom_range(0, 599)), 0, 799);
          idle(int'($urandom_range(5, 20)));
        end
        disp_done = 1'b1;
      end
      begin
        while (!disp_done) begin
          repeat ($urandom_range(1, 4)) step();
          cpu_write(16'($urandom_range(60000, 65535)), 8'($urandom));
        end
      end
    join

    idle(8);
    chk("pix_q_empty", 32'(pix_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
